mc_processor: RTL and testbench
===============================

Name: mc_processor

Overview:
Parametrised multi-cycle RV32I-subset processor core, successor to the single-cycle PROCESSOR top. Executes R-type and I-type ALU instructions through a FETCH/DECODE/EXECUTE/WRITEBACK state machine. Fetches over a req/ack instruction-memory handshake, so the memory may have variable latency. Adds halt on ECALL/EBREAK or illegal instruction, a retire strobe, and a configurable datapath width and register count.

Parameters:
XLEN, 32, datapath, register and PC width; legal values 32 or 64.
NREGS, 32, number of architectural registers; legal values 16 or 32; x0 is hardwired to zero.
PC_RESET, 0, PC value after reset; must be 4-byte aligned.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
imem_req  out  1  fetch request.
imem_addr  out  XLEN  fetch address, equal to the PC.
imem_ack  in  1  fetch data valid.
imem_rdata  in  32  instruction word.
retire  out  1  one-cycle pulse when an instruction completes.
zero  out  1  registered flag: last ALU result == 0.
halted  out  1  core is stopped.
illegal  out  1  halt was caused by an illegal instruction.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, pc=PC_RESET, all registers 0.
  - imem_req, retire, zero, halted, illegal all 0.
- States and transitions:
  - IDLE -> FETCH on the first clock edge after reset release.
  - FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack=1 is sampled. On that edge, capture imem_rdata into the IR and go to DECODE. imem_ack is ignored outside FETCH.
  - DECODE: read rs1/rs2 and build the sign-extended immediate (XLEN bits). Classify the IR:
    - 0x00000073 or 0x00100073 -> HALT with illegal=0.
    - Unsupported opcode, funct3/funct7 combination, or register index >= NREGS -> HALT with illegal=1.
    - Otherwise -> EXECUTE.
  - EXECUTE: ALU computes the result; zero <= (result==0). -> WRITEBACK.
  - WRITEBACK: write rd unless rd==0; pc <= pc+4, wrapping modulo 2^XLEN; retire=1 for this cycle. -> FETCH.
  - HALT: terminal, left only by reset. halted=1, imem_req=0, no register or PC updates.
- Supported instructions:
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- Arithmetic and width rules:
  - Shift amount uses the low log2(XLEN) bits.
  - When XLEN=32, I-type shifts with imm[5]=1 are illegal.
  - Arithmetic wraps modulo 2^XLEN.
  - SLT/SLTU produce 0 or 1, zero-extended to XLEN.
- Timing: minimum 4 cycles per instruction when imem_ack is returned in the first FETCH cycle. Each extra wait cycle on imem_ack adds one cycle.
- x0 always reads as 0; writes to x0 are discarded, but zero still updates.
- Reset asserted mid-fetch: imem_req drops immediately (asynchronously); a pending ack is discarded.

Optional Feature:
MC_BRANCH_EN.
- Defined: BEQ and BNE are supported.
  - EXECUTE compares rs1 and rs2.
  - WRITEBACK sets pc <= taken ? pc+B-imm : pc+4, and pulses retire.
  - A taken target with bit[1] set -> HALT with illegal=1; retire is not pulsed and the PC is unchanged.
- Not defined: opcode 1100011 is illegal -> HALT with illegal=1.

Decomposition:
- Package mc_proc_pkg holds:
  - opcode, funct3 and funct7 constants;
  - the ECALL/EBREAK encodings;
  - the alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
  - the state_t enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT).
- One sub-module, mc_alu: combinational, parametrised by XLEN; inputs a, b, alu_op; outputs result.
- The register file stays inside mc_processor.

Test Plan:
- Reset, then a single-cycle-ack memory program "ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2" -> x3=2, retire pulses every 4 cycles, imem_addr sequence 0,4,8, zero=0 at the end.
- SUB x4,x1,x1 with x1=5 -> x4=0, zero=1. ADDI x0,x0,7 -> x0 still reads 0, retire pulses.
- ack delayed 3 cycles -> imem_req and imem_addr held stable for all 4 FETCH cycles, instruction period 7 cycles; an ack pulse while in EXECUTE is ignored.
- SRAI x5,x6,4 with x6=0x80000000 (XLEN=32) -> x5=0xF8000000. SLTU x7,x0,x6 -> x7=1. SLLI with imm[5]=1 -> halted=1, illegal=1.
- EBREAK (0x00100073) -> halted=1, illegal=0, imem_req stays 0, no further retire. Reset pulse while halted -> pc=PC_RESET, fetch restarts.
- With MC_BRANCH_EN defined: BEQ x1,x1,+8 at pc=0x10 -> next imem_addr=0x18. Without MC_BRANCH_EN: the same word -> halted=1, illegal=1.

Source files
------------

// File: rtl/mc_proc_pkg.sv
// ----------------------------------------------------------------------------
// mc_proc_pkg: shared encodings, ALU operation and FSM state types for mc_processor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mc_proc_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_HALT
  } state_t;

  // alt selects SUB/SRA (funct7 bit 5 / imm[10])
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_alu.sv
// ----------------------------------------------------------------------------
// mc_alu: combinational XLEN-wide integer ALU for mc_processor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc_alu
  import mc_proc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         alu_op,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_sh;
  assign w_sh = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << w_sh;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> w_sh;
      ALU_SRA:  result = $unsigned($signed(a) >>> w_sh);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_processor.sv
// ----------------------------------------------------------------------------
// mc_processor: multi-cycle RV32I-subset core; BEQ/BNE enabled by MC_BRANCH_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc_processor
  import mc_proc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            retire,
  output logic            zero,
  output logic            halted,
  output logic            illegal
);

  localparam int IDXW = $clog2(NREGS);

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;
  logic [XLEN-1:0] r_regs [NREGS];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_alu_res;
  logic [XLEN-1:0] w_pc_plus4;
  alu_op_t         w_op;
  logic            w_legal;
  logic            w_use_imm;
  logic            w_is_branch;
  logic            w_shamt_ok;
  logic            w_bad_reg;
  logic            w_is_sys;
  logic            w_wen;
  logic            w_stop_illegal;
  logic            w_taken;
  logic [XLEN-1:0] w_target;

  // The IR stays valid from DECODE through WRITEBACK, so decode is purely combinational.
  assign w_opcode   = r_ir[6:0];
  assign w_rd       = r_ir[11:7];
  assign w_f3       = r_ir[14:12];
  assign w_rs1      = r_ir[19:15];
  assign w_rs2      = r_ir[24:20];
  assign w_f7       = r_ir[31:25];
  assign w_imm_i    = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_rs1_val  = r_regs[w_rs1[IDXW-1:0]];
  assign w_rs2_val  = r_regs[w_rs2[IDXW-1:0]];
  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_shamt_ok = (XLEN == 64) || !r_ir[25];
  assign w_is_sys   = (r_ir == INSN_ECALL) || (r_ir == INSN_EBREAK);
  assign w_wen      = (w_rd != 5'd0) && !w_is_branch;
  assign w_bad_reg  = (int'(w_rs1) >= NREGS)
                   || (!w_use_imm && (int'(w_rs2) >= NREGS))
                   || (!w_is_branch && (int'(w_rd) >= NREGS));

`ifdef MC_BRANCH_EN
  logic [XLEN-1:0] w_imm_b;
  assign w_imm_b  = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_taken  = w_is_branch && (w_f3[0] ? (r_a != r_b) : (r_a == r_b));
  assign w_target = r_pc + w_imm_b;
`else
  assign w_taken  = 1'b0;
  assign w_target = w_pc_plus4;
`endif

  always_comb begin
    w_op        = ALU_ADD;
    w_legal     = 1'b0;
    w_use_imm   = 1'b0;
    w_is_branch = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          w_legal = 1'b1;
          w_op    = f3_to_alu(w_f3, 1'b0);
        end else if ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR))) begin
          w_legal = 1'b1;
          w_op    = f3_to_alu(w_f3, 1'b1);
        end
      end
      OPC_OP_IMM: begin
        w_use_imm = 1'b1;
        case (w_f3)
          F3_SLL: begin
            w_legal = (w_f7[6:1] == 6'd0) && w_shamt_ok;
            w_op    = ALU_SLL;
          end
          F3_SR: begin
            w_legal = ((w_f7[6:1] == 6'd0) || (w_f7[6:1] == F7_ALT[6:1])) && w_shamt_ok;
            w_op    = w_f7[5] ? ALU_SRA : ALU_SRL;
          end
          default: begin
            w_legal = 1'b1;
            w_op    = f3_to_alu(w_f3, 1'b0);
          end
        endcase
      end
`ifdef MC_BRANCH_EN
      OPC_BRANCH: begin
        w_is_branch = 1'b1;
        w_op        = ALU_SUB;
        w_legal     = (w_f3 == F3_BEQ) || (w_f3 == F3_BNE);
      end
`endif
      default: ;
    endcase
  end

  mc_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a      (r_a),
    .b      (r_b),
    .alu_op (w_op),
    .result (w_alu_res)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_stop_illegal = 1'b0;
    case (r_state)
      ST_IDLE:  w_next = ST_FETCH;
      ST_FETCH: if (imem_ack) w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_is_sys) begin
          w_next = ST_HALT;
        end else if (!w_legal || w_bad_reg) begin
          w_next         = ST_HALT;
          w_stop_illegal = 1'b1;
        end else begin
          w_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        // A misaligned taken branch stops before WRITEBACK so it never retires.
        if (w_taken && w_target[1]) begin
          w_next         = ST_HALT;
          w_stop_illegal = 1'b1;
        end else begin
          w_next = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: w_next = ST_FETCH;
      ST_HALT:      w_next = ST_HALT;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc      <= PC_RESET;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_stop_illegal) r_illegal <= 1'b1;
      case (r_state)
        ST_FETCH: if (imem_ack) r_ir <= imem_rdata;
        ST_DECODE: begin
          r_a <= w_rs1_val;
          r_b <= w_use_imm ? w_imm_i : w_rs2_val;
        end
        ST_EXECUTE: begin
          r_result <= w_alu_res;
          r_zero   <= (w_alu_res == '0);
        end
        ST_WRITEBACK: begin
          if (w_wen) r_regs[w_rd[IDXW-1:0]] <= r_result;
          r_pc <= w_taken ? w_target : w_pc_plus4;
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign retire    = (r_state == ST_WRITEBACK);
  assign zero      = r_zero;
  assign halted    = (r_state == ST_HALT);
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_mc_processor.sv
// ----------------------------------------------------------------------------
// tb_mc_processor: random and directed programs against an instruction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mc_processor;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        retire;
  logic        zero;
  logic        halted;
  logic        illegal;

  mc_processor #(
    .XLEN(32), .NREGS(32), .PC_RESET(32'h0)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .retire(retire), .zero(zero), .halted(halted), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [31:0] mem [64];
  int          lat      = 0;
  bit          rand_lat = 0;
  bit          stray_en = 0;
  int          cur_lat  = 0;
  int          wait_cnt = 0;
  int          cyc      = 0;
  int          unstable = 0;
  logic        prev_req = 0;
  logic [31:0] prev_addr = 0;

  logic [31:0] obs_fetch[$];
  bit          obs_zero[$];
  int          obs_ret_cyc[$];
  logic [31:0] exp_fetch[$];
  bit          exp_zero[$];
  logic [31:0] m_regs [32];

  // Monitor plus variable-latency memory; stray acks are thrown in outside FETCH.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if (imem_req && !prev_req) obs_fetch.push_back(imem_addr);
        if (imem_req && prev_req && (imem_addr != prev_addr)) unstable++;
        if (retire) begin
          obs_ret_cyc.push_back(cyc);
          obs_zero.push_back(zero);
        end
      end
      prev_req  = imem_req;
      prev_addr = imem_addr;
      if (imem_req) begin
        if (wait_cnt >= cur_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr[7:2]];
          wait_cnt   = 0;
          cur_lat    = rand_lat ? int'($urandom_range(0, 3)) : lat;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = $urandom;
        wait_cnt   = 0;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Instruction-level reference: runs the program from mem, returns how it stops.
  task automatic model_run(output bit ill);
    logic [31:0] pc, ins, a, b, r, tgt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    bit          ok, alt;
    pc = 0;
    ill = 0;
    exp_fetch.delete();
    exp_zero.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    for (int step = 0; step < 64; step++) begin
      ins = mem[pc[7:2]];
      exp_fetch.push_back(pc);
      if (ins == 32'h0000_0073 || ins == 32'h0010_0073) return;
      opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
      rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
      a = m_regs[rs1];
      b = 0; ok = 0; alt = 0;
      if (opc == 7'h33) begin
        b   = m_regs[rs2];
        alt = f7[5];
        ok  = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end else if (opc == 7'h13) begin
        b   = {{20{ins[31]}}, ins[31:20]};
        alt = (f3 == 5) && ins[30];
        if (f3 == 1)      ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
        else              ok = 1;
      end
`ifdef MC_BRANCH_EN
      else if (opc == 7'h63 && (f3 == 0 || f3 == 1)) begin
        b   = m_regs[rs2];
        tgt = pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (((a == b) ^ f3[0]) && tgt[1]) begin ill = 1; return; end
        exp_zero.push_back(a == b);
        pc = ((a == b) ^ f3[0]) ? tgt : pc + 4;
        continue;
      end
`endif
      if (!ok) begin ill = 1; return; end
      case (f3)
        3'd0: r = alt ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = ($signed(a) < $signed(b)) ? 1 : 0;
        3'd3: r = (a < b) ? 1 : 0;
        3'd4: r = a ^ b;
        3'd5: r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
      exp_zero.push_back(r == 0);
      if (rd != 0) m_regs[rd] = r;
      pc = pc + 4;
    end
  endtask

  task automatic run_prog(input string tag, input bit chk_period);
    bit exp_ill;
    int t, n, nmin;
    model_run(exp_ill);
    reset = 1'b0;
    obs_fetch.delete(); obs_zero.delete(); obs_ret_cyc.delete();
    unstable = 0;
    cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : lat;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    t = 0;
    while (!halted && t < 3000) begin @(negedge clock); t++; end
    chk({tag, ".halted"}, halted, 1);
    chk({tag, ".illegal"}, illegal, exp_ill);
    chk({tag, ".n_fetch"}, obs_fetch.size(), exp_fetch.size());
    chk({tag, ".n_retire"}, obs_zero.size(), exp_zero.size());
    nmin = (obs_fetch.size() < exp_fetch.size()) ? obs_fetch.size() : exp_fetch.size();
    for (int i = 0; i < nmin; i++) chk($sformatf("%s.addr%0d", tag, i), obs_fetch[i], exp_fetch[i]);
    nmin = (obs_zero.size() < exp_zero.size()) ? obs_zero.size() : exp_zero.size();
    for (int i = 0; i < nmin; i++) chk($sformatf("%s.zero%0d", tag, i), obs_zero[i], exp_zero[i]);
    if (chk_period)
      for (int i = 1; i < obs_ret_cyc.size(); i++)
        chk($sformatf("%s.period%0d", tag, i), obs_ret_cyc[i] - obs_ret_cyc[i-1], 4 + lat);
    for (int i = 0; i < 32; i++) chk($sformatf("%s.x%0d", tag, i), dut.r_regs[i], m_regs[i]);
    chk({tag, ".addr_stable"}, unstable, 0);
    n = obs_ret_cyc.size();
    repeat (8) @(negedge clock);
    chk({tag, ".no_retire_after_halt"}, obs_ret_cyc.size(), n);
    chk({tag, ".req_low_halted"}, imem_req, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic gen_random(input int n);
    int k;
    logic [2:0] f3;
    logic [4:0] sh;
    bit alt;
    clear_mem();
    for (int i = 0; i < 5; i++)
      mem[i] = enc_i(12'($urandom), 5'd0, 3'd0, 5'($urandom_range(1, 31)));
    for (int i = 5; i < n; i++) begin
      f3  = 3'($urandom);
      alt = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1);
      sh  = 5'($urandom);
      if ($urandom_range(0, 1) == 1)
        mem[i] = enc_r(alt ? 7'h20 : 7'h00, 5'($urandom), 5'($urandom), f3, 5'($urandom));
      else if (f3 == 1 || f3 == 5)
        mem[i] = enc_i({(alt && f3 == 5) ? 7'h20 : 7'h00, sh}, 5'($urandom), f3, 5'($urandom));
      else
        mem[i] = enc_i(12'($urandom), 5'($urandom), f3, 5'($urandom));
    end
    k = $urandom_range(0, 2);
    mem[n] = (k == 0) ? 32'h0010_0073 : (k == 1) ? 32'h0000_0073 : enc_r(7'h01, 5'd1, 5'd2, 3'd0, 5'd3);
  endtask

  initial begin
    int t;
    reset = 1'b0;
    clear_mem();
    repeat (3) @(negedge clock);
    chk("rst.imem_req", imem_req, 0);
    chk("rst.imem_addr", imem_addr, 0);
    chk("rst.retire", retire, 0);
    chk("rst.zero", zero, 0);
    chk("rst.halted", halted, 0);
    chk("rst.illegal", illegal, 0);

    // ADDI/ADD/SUB/x0 program, single-cycle ack
    mem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    mem[1] = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    mem[3] = enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd4);
    mem[4] = enc_i(12'd7, 5'd0, 3'd0, 5'd0);
    mem[5] = 32'h0010_0073;
    lat = 0; rand_lat = 0; stray_en = 0;
    run_prog("p1", 1);
    chk("p1.x3_is_2", dut.r_regs[3], 32'd2);
    chk("p1.ebreak_not_illegal", illegal, 0);

    // Shifts/SLTU then an RV32 SLLI with imm[5]=1; 3-cycle ack delay and stray acks
    clear_mem();
    mem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd6);
    mem[1] = enc_i(12'd31, 5'd6, 3'd1, 5'd6);
    mem[2] = enc_i({7'h20, 5'd4}, 5'd6, 3'd5, 5'd5);
    mem[3] = enc_r(7'h00, 5'd6, 5'd0, 3'd3, 5'd7);
    mem[4] = enc_i(12'h020, 5'd1, 3'd1, 5'd8);
    lat = 3; stray_en = 1;
    run_prog("p3", 1);
    chk("p3.x5_sra", dut.r_regs[5], 32'hF800_0000);
    chk("p3.x7_sltu", dut.r_regs[7], 32'd1);
    chk("p3.slli_illegal", illegal, 1);

    // BEQ x1,x1,+8 at 0x10
    clear_mem();
    mem[0] = enc_i(12'd3, 5'd0, 3'd0, 5'd1);
    mem[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd2);
    mem[2] = enc_i(12'd2, 5'd0, 3'd0, 5'd3);
    mem[3] = enc_i(12'd4, 5'd0, 3'd0, 5'd4);
    mem[4] = 32'h0010_8463;
    mem[5] = enc_i(12'd9, 5'd0, 3'd0, 5'd9);
    mem[6] = 32'h0010_0073;
    lat = 0; stray_en = 0;
    run_prog("br", 1);
`ifdef MC_BRANCH_EN
    chk("br.target_fetch", (obs_fetch.size() > 5) ? obs_fetch[5] : 32'hDEAD_BEEF, 32'h18);
`else
    chk("br.illegal", illegal, 1);
`endif

    // Reset asserted while a fetch is waiting for ack
    clear_mem();
    mem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    mem[1] = 32'h0010_0073;
    lat = 3; cur_lat = 3;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    t = 0;
    while (!imem_req && t < 20) begin @(negedge clock); t++; end
    chk("midrst.req_before", imem_req, 1);
    #2 reset = 1'b0;
    #1 chk("midrst.req_async_drop", imem_req, 0);
    chk("midrst.addr", imem_addr, 0);
    run_prog("midrst", 1);

    // Randomised programs with random per-fetch latency
    rand_lat = 1; stray_en = 1;
    for (int r = 0; r < 4; r++) begin
      gen_random(20);
      run_prog($sformatf("rnd%0d", r), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
